lookup_table_programmer: RTL
============================

Name: lookup_table_programmer

Overview:
- Control-plane writer for one pipeline stage's lookup engine.
- Accepts 32-bit config beats on a valid/ready stream and assembles TCAM key/mask entries and action-RAM entries.
- Drives the lookup engine's control write channels: lookup_din/lookup_din_mask/lookup_din_addr/lookup_din_en and action_data_in/action_addr/action_en.
- Entries addressed to a different stage are consumed and dropped.

Parameters:
- STAGE, 0, stage id this instance accepts (4-bit compare)
- KEY_LEN, 896, TCAM key width
- MASK_LEN, 896, TCAM mask width (== KEY_LEN)
- ACTION_LEN, 25, action word width
- ADDR_W, 4, entry address width (16 entries)

Ports:
- axis_clk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- cfg_data  in  32  config beat
- cfg_valid  in  1  beat valid
- cfg_last  in  1  final beat of a config message
- cfg_ready  out  1  beat accepted when cfg_valid & cfg_ready
- lookup_din  out  KEY_LEN  TCAM key to write
- lookup_din_mask  out  MASK_LEN  TCAM mask to write
- lookup_din_addr  out  ADDR_W  TCAM entry address
- lookup_din_en  out  1  one-cycle TCAM write strobe
- action_data_in  out  ACTION_LEN  action word to write
- action_addr  out  ADDR_W  action RAM address
- action_en  out  1  one-cycle action write strobe
- busy  out  1  state != IDLE
- err_pulse  out  1  one-cycle error indication

Behaviour:
- Reset (async, areset=1): all outputs 0, accumulators 0, state IDLE. The deassertion edge is synchronised internally (two-flop).
- Header beat (first beat in IDLE):
  - [31:28] opcode: 4'h1 = TCAM entry, 4'h2 = action entry.
  - [27:24] stage id.
  - [ADDR_W-1:0] address.
  - All other bits are ignored.
- Beat counts:
  - KEY_BEATS = ceil(KEY_LEN/32) = 28; MASK_BEATS is the same.
  - ACT_BEATS = ceil(ACTION_LEN/32) = 1.
- Beat packing: data beats are MSB-first into a shift-left accumulator of BEATS*32 bits; the low LEN bits are kept (excess top bits discarded).
- States:
  - IDLE: cfg_ready=1. On header accept: opcode 1 -> KEY, opcode 2 -> ACT, other -> err_pulse next cycle, stay IDLE.
  - KEY: accepts 28 beats, then -> MASK.
  - MASK: accepts 28 beats, then -> COMMIT.
  - ACT: accepts 1 beat, then -> COMMIT.
  - COMMIT: cfg_ready=0 for exactly one cycle.
    - If stage id == STAGE: assert lookup_din_en (TCAM) or action_en (action) with data/addr registered and stable.
    - Otherwise no strobe.
    - Next state IDLE.
- Latency: last data beat accepted at cycle N -> strobe high in cycle N+1 -> cfg_ready=1 again at N+2.
- Outputs: data/addr outputs hold their last committed value after the strobe drops. The two strobes are never high together.
- Stalls: cfg_valid low mid-message stalls the beat counter; there is no timeout.
- Reset mid-message aborts the message with no strobe; remaining beats are then parsed as a new header.
- Beat counter width is 5 bits, cleared on each state entry.

Optional Feature:
- LOOKUP_PROG_LAST_CHECK_EN:
  - Defined: framing check on cfg_last.
    - cfg_last on any beat before the final one, or missing on the final beat, drops the entry (no strobe), pulses err_pulse and returns to IDLE.
    - In the early-last case, return is immediately after that beat. In the missing-last case, beats are discarded until one with cfg_last=1.
    - A header with cfg_last=1 is an error.
  - Undefined: cfg_last ignored; framing is by beat count only. err_pulse only for bad opcode.

Decomposition:
- Shared package (lookup_pkg):
  - opcode constants OP_TCAM_WR=4'h1, OP_ACT_WR=4'h2
  - header field bit positions
  - state enum {IDLE, KEY, MASK, ACT, COMMIT}
  - beat-count function ceil_div32
- One natural sub-module: cfg_beat_accum, a parameterised shift accumulator with beat counter and done flag, instantiated for key, mask and action.

Test Plan:
- TCAM write, stage 0, addr 3: header 32'h1000_0003; 28 key beats of 32'hA5A5A5A5; 28 mask beats of 32'hFFFF0000 -> one cycle later lookup_din_en=1 for exactly 1 cycle, lookup_din={28{32'hA5A5A5A5}}, lookup_din_mask={28{32'hFFFF0000}}, lookup_din_addr=3, busy low 2 cycles after last beat.
- Action write: header 32'h2000_0007, data 32'h01FF_FFFF -> action_en=1 for 1 cycle, action_data_in=25'h1FF_FFFF, action_addr=7, lookup_din_en stays 0.
- Stage mismatch: header 32'h2100_0005 plus 1 data beat -> beat accepted, COMMIT cycle with action_en=0, outputs unchanged; next header accepted normally.
- Bad opcode 32'h7000_0000 -> err_pulse=1 for 1 cycle, busy stays 0, following action message completes normally.
- Backpressure and stall: cfg_valid toggled 1/0 every cycle through a TCAM message, plus areset=1 pulse at key beat 10 -> after reset all outputs 0, no strobe; then a full message still produces a correct write.
- With LOOKUP_PROG_LAST_CHECK_EN: cfg_last=1 on key beat 5 -> err_pulse, no lookup_din_en; without the macro the same stimulus completes normally with the strobe.

Source files
------------

// File: rtl/lookup_table_programmer_pkg.sv
// Shared definitions for the lookup table programmer: header opcodes, header
// field positions, controller states and the beat-count helper.
package lookup_pkg;

  localparam logic [3:0] OP_TCAM_WR = 4'h1;
  localparam logic [3:0] OP_ACT_WR  = 4'h2;

  localparam int HDR_OP_HI  = 31;
  localparam int HDR_OP_LO  = 28;
  localparam int HDR_STG_HI = 27;
  localparam int HDR_STG_LO = 24;

  // DRAIN is reachable only when cfg_last framing checks are compiled in
  typedef enum logic [2:0] {IDLE, KEY, MASK, ACT, COMMIT, DRAIN} state_t;

  function automatic int ceil_div32(input int len);
    return (len + 31) / 32;
  endfunction

endpackage

// File: rtl/lookup_table_programmer_cfg_beat_accum.sv
// MSB-first shift accumulator for 32-bit config beats with a 5-bit beat
// counter; done flags the beat that completes the entry.
module cfg_beat_accum #(
  parameter int LEN   = 896,
  parameter int BEATS = 28
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           shift,
  input  logic [31:0]    din,
  output logic [LEN-1:0] data,
  output logic           done
);

  logic [LEN-1:0] acc;
  logic [LEN-1:0] acc_shifted;
  logic [4:0]     cnt;

  // Only the low LEN bits of the BEATS*32 stream survive; older bits fall off the top
  assign acc_shifted = (acc << 32) | LEN'(din);
  // Value the accumulator holds after this edge, so a final beat is visible at once
  assign data        = shift ? acc_shifted : acc;
  assign done        = shift && (cnt == 5'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      if (shift) acc <= acc_shifted;
      if (clr)        cnt <= '0;
      else if (shift) cnt <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/lookup_table_programmer.sv
// Config-stream writer for one stage's TCAM and action RAM.
// Optional macro LOOKUP_PROG_LAST_CHECK_EN enables cfg_last framing checks.
module lookup_table_programmer #(
  parameter int STAGE      = 0,
  parameter int KEY_LEN    = 896,
  parameter int MASK_LEN   = 896,
  parameter int ACTION_LEN = 25,
  parameter int ADDR_W     = 4
) (
  input  logic                  axis_clk,
  input  logic                  areset,
  input  logic [31:0]           cfg_data,
  input  logic                  cfg_valid,
  input  logic                  cfg_last,
  output logic                  cfg_ready,
  output logic [KEY_LEN-1:0]    lookup_din,
  output logic [MASK_LEN-1:0]   lookup_din_mask,
  output logic [ADDR_W-1:0]     lookup_din_addr,
  output logic                  lookup_din_en,
  output logic [ACTION_LEN-1:0] action_data_in,
  output logic [ADDR_W-1:0]     action_addr,
  output logic                  action_en,
  output logic                  busy,
  output logic                  err_pulse
);
  import lookup_pkg::*;

  localparam int KEY_BEATS  = ceil_div32(KEY_LEN);
  localparam int MASK_BEATS = ceil_div32(MASK_LEN);
  localparam int ACT_BEATS  = ceil_div32(ACTION_LEN);

  logic [1:0] rst_q;
  logic       rst;
  state_t     state, state_nxt;
  logic       hs, hdr_hs, err_set, commit_go;
  logic [3:0] hdr_op, stage_q;
  logic [ADDR_W-1:0] addr_q;
  logic key_done, mask_done, act_done;
  logic [KEY_LEN-1:0]    key_data;
  logic [MASK_LEN-1:0]   mask_data;
  logic [ACTION_LEN-1:0] act_data;

  // Reset asserts immediately but releases two clocks after areset drops
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) rst_q <= 2'b11;
    else        rst_q <= {rst_q[0], 1'b0};
  end
  assign rst = rst_q[1];

  assign cfg_ready = !rst && (state != COMMIT);
  assign busy      = (state != IDLE);
  assign hs        = cfg_valid && cfg_ready;
  assign hdr_hs    = hs && (state == IDLE);
  assign hdr_op    = cfg_data[HDR_OP_HI:HDR_OP_LO];

  cfg_beat_accum #(.LEN(KEY_LEN), .BEATS(KEY_BEATS)) u_key (
    .clk(axis_clk), .rst(rst), .clr(hdr_hs), .shift(hs && state == KEY),
    .din(cfg_data), .data(key_data), .done(key_done));

  cfg_beat_accum #(.LEN(MASK_LEN), .BEATS(MASK_BEATS)) u_mask (
    .clk(axis_clk), .rst(rst), .clr(hdr_hs), .shift(hs && state == MASK),
    .din(cfg_data), .data(mask_data), .done(mask_done));

  cfg_beat_accum #(.LEN(ACTION_LEN), .BEATS(ACT_BEATS)) u_act (
    .clk(axis_clk), .rst(rst), .clr(hdr_hs), .shift(hs && state == ACT),
    .din(cfg_data), .data(act_data), .done(act_done));

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    commit_go = 1'b0;
    case (state)
      IDLE: if (hs) begin
        if (hdr_op == OP_TCAM_WR)     state_nxt = KEY;
        else if (hdr_op == OP_ACT_WR) state_nxt = ACT;
        else                          err_set   = 1'b1;
      end
      KEY:  if (key_done) state_nxt = MASK;
      MASK: if (mask_done) begin state_nxt = COMMIT; commit_go = 1'b1; end
      ACT:  if (act_done)  begin state_nxt = COMMIT; commit_go = 1'b1; end
      COMMIT: state_nxt = IDLE;
      DRAIN:  if (hs && cfg_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef LOOKUP_PROG_LAST_CHECK_EN
    if (hdr_hs && cfg_last) begin
      state_nxt = IDLE;
      err_set   = 1'b1;
    end
    if (hs && (state == KEY || state == MASK || state == ACT)) begin
      if (cfg_last && !commit_go) begin
        state_nxt = IDLE;
        err_set   = 1'b1;
      end else if (commit_go && !cfg_last) begin
        // Entry is dropped; swallow beats until the sender closes the message
        state_nxt = DRAIN;
        err_set   = 1'b1;
        commit_go = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      addr_q  <= '0;
    end else if (hdr_hs) begin
      stage_q <= cfg_data[HDR_STG_HI:HDR_STG_LO];
      addr_q  <= cfg_data[ADDR_W-1:0];
    end
  end

  // Write channel is loaded on the final beat so the strobe cycle is COMMIT
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      lookup_din      <= '0;
      lookup_din_mask <= '0;
      lookup_din_addr <= '0;
      lookup_din_en   <= 1'b0;
      action_data_in  <= '0;
      action_addr     <= '0;
      action_en       <= 1'b0;
      err_pulse       <= 1'b0;
    end else begin
      err_pulse     <= err_set;
      lookup_din_en <= 1'b0;
      action_en     <= 1'b0;
      if (commit_go && stage_q == 4'(STAGE)) begin
        if (state == MASK) begin
          lookup_din      <= key_data;
          lookup_din_mask <= mask_data;
          lookup_din_addr <= addr_q;
          lookup_din_en   <= 1'b1;
        end else begin
          action_data_in <= act_data;
          action_addr    <= addr_q;
          action_en      <= 1'b1;
        end
      end
    end
  end

endmodule
